// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and operand types for the MAC datapath
//
// Purpose: constants and types shared by mac_operand_fifo and part1_mac.
//   DATA_W         operand width (signed), matches MAC a/b inputs
//   ACC_W          MAC accumulator width
//   operand_pair_t one {a, b} operand pair as stored in the FIFO
package mac_pkg;

  localparam int DATA_W = 10;
  localparam int ACC_W  = 20;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/mac_fifo_mem.sv
// rtl/mac_fifo_mem.sv - operand pair storage array for mac_operand_fifo
//
// Purpose: DEPTH-entry register array, one synchronous write port and one
// asynchronous read port. Storage is deliberately not reset; validity of
// each entry is tracked by the owning FIFO's pointers and count.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data (W bits)
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr
module mac_fifo_mem #(
  parameter int W     = 20,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_operand_fifo.sv
// rtl/mac_operand_fifo.sv - buffered operand pair source feeding part1_mac
//
// Purpose: accepts signed (a, b) pairs via valid/ready, stores up to DEPTH
// of them and replays them in order onto registered MAC inputs, honouring a
// downstream stall. No bypass: a pair pushed into an empty buffer is popped
// at the following edge at the earliest.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   a_in/b_in  in   operand pair from producer
//   valid_in   in   producer presents a pair
//   ready_out  out  pair can be accepted this cycle
//   stall_in   in   downstream hold, blocks pops
//   a_out/b_out out registered operands to MAC a/b
//   valid_out  out  registered, one cycle per popped pair
//   count      out  number of stored pairs
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           a_in,
  input  logic [WIDTH-1:0]           b_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic                       stall_in,
  output logic [WIDTH-1:0]           a_out,
  output logic [WIDTH-1:0]           b_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [2*WIDTH-1:0] head_pair;
  logic               push;
  logic               pop;

  // Full blocks a push even when a pop frees a slot in the same cycle:
  // ready_out is driven only from registered count, never from the pop path.
  assign ready_out = !reset && (count != FULL_COUNT);
  assign push      = valid_in && ready_out;
  assign pop       = (count != '0) && !stall_in;

  mac_fifo_mem #(
    .W     (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({a_in, b_in}),
    .raddr (rd_ptr),
    .rdata (head_pair)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        a_out  <= head_pair[2*WIDTH-1:WIDTH];
        b_out  <= head_pair[WIDTH-1:0];
      end
      valid_out <= pop;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_fifo.sv
// tb/tb_mac_operand_fifo.sv - self-checking bench for mac_operand_fifo
module tb_mac_operand_fifo;

  localparam int W = 10;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic         stall_in = 1'b0;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic         valid_out;
  logic [3:0]   count;

  int     n_checks = 0;
  int     n_fail = 0;
  int     q_a[$];
  int     q_b[$];
  int     exp_a = 0;
  int     exp_b = 0;
  bit     exp_v = 1'b0;
  int     obs[$];
  longint acc = 0;

  always #5 clk = ~clk;

  mac_operand_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .stall_in  (stall_in),
    .a_out     (a_out),
    .b_out     (b_out),
    .valid_out (valid_out),
    .count     (count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the queue model
  // at the rising edge, compare every DUT output at the next falling edge.
  task automatic step(input int a, input int b, input bit v, input bit s, input bit r);
    bit do_pop;
    bit do_push;
    a_in = W'(a);
    b_in = W'(b);
    valid_in = v;
    stall_in = s;
    reset = r;
    #1;
    chk("ready_out", int'(ready_out), int'(!r && (q_a.size() != D)));
    @(posedge clk);
    if (r) begin
      q_a.delete();
      q_b.delete();
      exp_v = 1'b0;
      exp_a = 0;
      exp_b = 0;
    end else begin
      do_pop  = (q_a.size() != 0) && !s;
      do_push = v && (q_a.size() != D);
      if (do_pop) begin
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
      end
      exp_v = do_pop;
      if (do_push) begin
        q_a.push_back(a);
        q_b.push_back(b);
      end
    end
    @(negedge clk);
    chk("count", int'(count), q_a.size());
    chk("valid_out", int'(valid_out), int'(exp_v));
    chk("a_out", int'($signed(a_out)), exp_a);
    chk("b_out", int'($signed(b_out)), exp_b);
    if (valid_out) begin
      obs.push_back(int'($signed(a_out)));
      acc += longint'($signed(a_out)) * longint'($signed(b_out));
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q_a.size() != 0; k++) step(0, 0, 0, 0, 0);
    chk("drain_count", int'(count), 0);
  endtask

  initial begin
    int idx;
    bit taken;

    @(negedge clk);
    step(0, 0, 0, 0, 1);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_ready", int'(ready_out), 0);

    // back-to-back (2,2),(3,3), accumulated as the MAC would
    acc = 0;
    step(2, 2, 1, 0, 0);
    chk("t1_nobypass", int'(valid_out), 0);
    step(3, 3, 1, 0, 0);
    chk("t1_a0", int'($signed(a_out)), 2);
    chk("t1_f0", int'(acc), 4);
    step(0, 0, 0, 0, 0);
    chk("t1_a1", int'($signed(a_out)), 3);
    chk("t1_f1", int'(acc), 13);
    chk("t1_count", int'(count), 0);

    // fill under stall, reject 9th, release
    for (int i = 1; i <= 8; i++) step(i, i, 1, 1, 0);
    chk("t2_full", int'(count), 8);
    chk("t2_ready", int'(ready_out), 0);
    chk("t2_valid", int'(valid_out), 0);
    step(9, 9, 1, 1, 0);
    chk("t2_reject", int'(count), 8);
    obs.delete();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    chk("t2_nout", obs.size(), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++) chk("t2_order", obs[i], i + 1);

    // full, stall released, producer always valid
    for (int i = 1; i <= 8; i++) step(20 + i, -i, 1, 1, 0);
    step(100, 1, 1, 0, 0);
    chk("t3_fullpop", int'(count), 7);
    step(101, 2, 1, 0, 0);
    chk("t3_steady", int'(count), 7);
    for (int i = 0; i < 10; i++) step(102 + i, 3, 1, 0, 0);
    drain();

    // -5..14 with random stall, producer holds until taken
    obs.delete();
    idx = 0;
    for (int k = 0; k < 300 && idx < 20; k++) begin
      taken = (q_a.size() != D);
      step(idx - 5, 5 - idx, 1, bit'($urandom_range(0, 1)), 0);
      if (taken) idx++;
    end
    chk("t4_pushed", idx, 20);
    drain();
    chk("t4_nout", obs.size(), 20);
    for (int i = 0; i < 20 && i < obs.size(); i++) chk("t4_order", obs[i], i - 5);

    // no bypass into empty, simultaneous push/pop at count 3
    step(0, 0, 0, 0, 1);
    step(7, 7, 1, 0, 0);
    chk("t5_nobypass", int'(valid_out), 0);
    chk("t5_count1", int'(count), 1);
    step(8, 8, 1, 1, 0);
    step(9, 9, 1, 1, 0);
    chk("t5_count3", int'(count), 3);
    step(10, 10, 1, 0, 0);
    chk("t5_same", int'(count), 3);
    chk("t5_valid", int'(valid_out), 1);
    chk("t5_a", int'($signed(a_out)), 7);
    drain();

    // reset mid-operation
    for (int i = 0; i < 6; i++) step(30 + i, i, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_pre_count", int'(count), 5);
    chk("t6_pre_valid", int'(valid_out), 1);
    step(0, 0, 1, 0, 1);
    chk("t6_count", int'(count), 0);
    chk("t6_valid", int'(valid_out), 0);
    chk("t6_a", int'(a_out), 0);
    chk("t6_b", int'(b_out), 0);
    chk("t6_ready", int'(ready_out), 0);
    step(0, 0, 0, 0, 0);
    chk("t6_idle", int'(valid_out), 0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      step(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
           bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 149) == 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_operand_fifo.md
# mac_operand_fifo

Buffered operand source sitting directly upstream of the `part1_mac` multiply-accumulate stage. It accepts signed (a, b) operand pairs through a valid/ready handshake, stores up to DEPTH pairs, and replays them in order onto the MAC's `a`, `b`, `valid_in` inputs from registered outputs. The MAC has no back-pressure, so this block absorbs producer burstiness and honours a downstream `stall_in`.

## Interface
- `WIDTH`, default 10: operand width, signed two's complement; matches the MAC `a`/`b` width.
- `DEPTH`, default 8: pair capacity; must be a power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_in`  in  WIDTH  operand a from producer (signed).
- `b_in`  in  WIDTH  operand b from producer (signed).
- `valid_in`  in  1  producer has a pair on `a_in`/`b_in`.
- `ready_out`  out  1  block can accept a pair this cycle.
- `stall_in`  in  1  downstream hold; no pop while high.
- `a_out`  out  WIDTH  operand a to MAC `a` (registered).
- `b_out`  out  WIDTH  operand b to MAC `b` (registered).
- `valid_out`  out  1  to MAC `valid_in` (registered); high exactly one cycle per popped pair.
- `count`  out  $clog2(DEPTH+1)  number of pairs currently stored.

## Operation
- Push: `valid_in && ready_out` at a rising edge writes {a_in, b_in} at write pointer, increments write pointer (mod DEPTH).
- `ready_out = !reset && (count != DEPTH)`; combinational from registered count only, never from `valid_in`.
- Pop: `(count != 0) && !stall_in` at a rising edge loads head pair into `a_out`/`b_out`, sets `valid_out`=1, increments read pointer (mod DEPTH).
- No pop at an edge: `valid_out`←0; `a_out`/`b_out` hold previous values.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push and pop in same cycle (count between 1 and DEPTH−1): both occur, count unchanged.
- Full (count = DEPTH): `ready_out`=0; pop still allowed; no push that cycle even though a slot frees.
- Empty (count = 0): no bypass; a pair pushed into an empty buffer is popped no earlier than the next edge.
- Pointers are log2(DEPTH) bits, wrap naturally; no separate full/empty flags beyond `count`.
- Data is passed bit-exact; no arithmetic on operands.
- `valid_in` high while `ready_out` low: pair is not taken; producer must hold it.

## Timing
- Reset (edge with `reset`=1): count=0, pointers=0, `valid_out`=0, `a_out`=`b_out`=0; `ready_out`=0 while `reset` high, 1 from the first cycle after release.
- Reset mid-operation: stored pairs discarded; any pending `valid_out` cleared at that edge; push/pop inputs ignored during reset.
- Minimum latency: pair pushed at edge N appears with `valid_out`=1 after edge N+1 (2 edges from presentation to visible output).
- Throughput: one pair per cycle sustained when not stalled and not full.
- `stall_in` sampled at the edge; asserting it at edge N makes `valid_out`=0 after edge N.
- Order preserved strictly FIFO across wrap-around.

## Structure
- Package `mac_pkg`: `DATA_W`=10, `ACC_W`=20 constants, shared with `part1_mac`; typedef `operand_pair_t` packed struct {logic signed [DATA_W-1:0] a, b}.
- One sub-module, `mac_fifo_mem`: DEPTH-entry register array, one synchronous write port, one asynchronous read port; no reset on storage.
- Top holds pointers, count, handshake logic and output registers.

## Test plan
- Reset then push (2,2),(3,3) back-to-back, stall_in=0 -> valid_out high after 3rd and 4th edges with (2,2),(3,3); count returns to 0; fed to `part1_mac`, f=4 then 13.
- Hold stall_in=1, push 8 pairs (1..8) -> count=8, ready_out=0, valid_out=0; 9th valid_in pair not accepted; release stall -> 1..8 out on 8 consecutive cycles.
- Full with stall released and valid_in high -> pop each cycle, push only when count<8; output sequence stays in order, no loss, no duplicate.
- Push 20 pairs (−5..14) with random stall_in -> output order exactly −5..14, negative values bit-exact; pointer wrap exercised twice.
- Push into empty and simultaneous push/pop at count=3 -> no bypass (valid_out 0 on same edge as first push); count stays 3.
- Assert reset with count=5 and valid_out=1 -> after edge: count=0, valid_out=0, a_out=b_out=0, ready_out=0; one cycle after release ready_out=1 and nothing is emitted.
